// File: rtl/boot_pkg.sv
// Shared types and widths for the byte-stream program loader.
package boot_pkg;

  localparam int BOOT_WORD_W = 16;
  localparam int BOOT_BYTE_W = 8;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// Loads a length-prefixed big-endian word image from a valid/ready byte stream into word memory,
// writing 1 cycle after each LO byte and then releasing the CPU; optional trailing XOR byte under BOOT_CHECKSUM_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [BOOT_BYTE_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BOOT_WORD_W-1:0] mem_data,
  output logic                   cpu_run,
  output logic                   busy,
  output logic                   err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  boot_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BOOT_BYTE_W-1:0] hi_q, hi_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      maddr_q, maddr_d;
  logic [BOOT_WORD_W-1:0] mdata_q, mdata_d;
  logic                   rdy_q, rdy_d;
  logic                   run_q, run_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   accept;
`ifdef BOOT_CHECKSUM_EN
  logic [BOOT_BYTE_W-1:0] csum_q, csum_d;
`endif

  assign accept = in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      COUNT: begin
`ifdef BOOT_CHECKSUM_EN
        csum_d = '0;
`endif
        if (accept) begin
          // N = 0 encodes a full-capacity image
          if (32'(in_data) > 32'(CAP)) begin
            state_d = ERR;
          end else begin
            cnt_d   = (in_data == '0) ? CAP : CNT_W'(in_data);
            addr_d  = '0;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (accept) begin
          hi_d    = in_data;
`ifdef BOOT_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          state_d = LO;
        end
      end
      LO: begin
        if (accept) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          mdata_d = {hi_q, in_data};
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
          state_d = (cnt_q == CNT_W'(1)) ? CSUM : HI;
`else
          state_d = (cnt_q == CNT_W'(1)) ? DONE : HI;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: ;
    endcase

    rdy_d  = state_d inside {COUNT, HI, LO, CSUM};
    busy_d = state_d inside {HI, LO, CSUM};
    err_d  = (state_d == ERR);
    // Hold the CPU until the final write pulse has been seen by memory
    run_d  = (state_d == DONE) && !we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COUNT;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      rdy_q   <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      rdy_q   <= rdy_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign in_ready = rdy_q;
  assign mem_we   = we_q;
  assign mem_addr = maddr_q;
  assign mem_data = mdata_q;
  assign cpu_run  = run_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of count-byte boundaries, hand sequences, and random loads vs a stream-level model.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int ADDR_W = 7;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, cpu_run, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_run(cpu_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory stand-in plus a log of every write pulse
  typedef struct { int cyc; int addr; int data; } wr_t;
  logic [15:0] mem [CAP];
  wr_t         wq[$];
  bit          run_seen, err_seen;
  int          run_cyc, err_cyc;

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_data;
      wq.push_back('{cyc, int'(mem_addr), int'(mem_data)});
    end
    if (cpu_run && !run_seen) begin run_seen = 1'b1; run_cyc = cyc; end
    if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0] s[$];
  int         acc_cyc[$];

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {4'b0, in_ready, mem_we, mem_addr, mem_data, cpu_run, busy, err}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wq.delete(); acc_cyc.delete();
    run_seen = 1'b0; err_seen = 1'b0;
  endtask

  // Present one byte after glo..ghi idle cycles; returns once accepted (bounded)
  task automatic push(input logic [7:0] b, input int glo, input int ghi, output bit ok);
    int g;
    bit r;
    g = $urandom_range(ghi, glo);
    for (int i = 0; i < g; i++) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = b; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; acc_cyc.push_back(cyc); end
    end
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic mk(input int n);
    int w;
    s.delete();
    s.push_back(8'(n));
    w = (n > CAP) ? 0 : ((n == 0) ? CAP : n);
    for (int i = 0; i < 2 * w; i++) s.push_back(8'($urandom));
  endtask

  task automatic add_csum(input bit corrupt);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < s.size(); i++) x ^= s[i];
    if (int'(s[0]) <= CAP) s.push_back(corrupt ? (x ^ 8'h01) : x);
`else
    if (corrupt) s.push_back(8'h00);
`endif
  endtask

  // Stream-level reference: derive words, final status and timing from the byte list
  task automatic run_stream(input string tag, input int glo, input int ghi);
    int n, words, nacc, exp_run;
    bit exp_err, ok;
    int bad_a, bad_d, bad_c;
    n = int'(s[0]);
    exp_err = (n > CAP);
    words = exp_err ? 0 : ((n == 0) ? CAP : n);
    nacc = 1 + 2 * words;
`ifdef BOOT_CHECKSUM_EN
    if (!exp_err) begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 1; i <= 2 * words; i++) x ^= s[i];
      exp_err = (s[nacc] != x);
      nacc++;
    end
`endif
    wq.delete(); acc_cyc.delete();
    run_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < nacc; i++) begin
      push(s[i], glo, ghi, ok);
      if (!ok) begin
        chk($sformatf("%s_accept_byte%0d", tag, i), 0, 1);
        break;
      end
    end
    chk($sformatf("%s_rdy_after", tag), in_ready, 0);
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("%s_wr_count", tag), wq.size(), words);
    bad_a = 0; bad_d = 0; bad_c = 0;
    for (int i = 0; i < wq.size() && i < words; i++) begin
      if (wq[i].addr != i) bad_a++;
      if (wq[i].data != {s[1+2*i], s[2+2*i]}) bad_d++;
      if (acc_cyc.size() > 2 + 2 * i && wq[i].cyc != acc_cyc[2+2*i]) bad_c++;
    end
    if (words > 0) begin
      chk($sformatf("%s_wr_addr_bad", tag), bad_a, 0);
      chk($sformatf("%s_wr_data_bad", tag), bad_d, 0);
      chk($sformatf("%s_wr_cycle_bad", tag), bad_c, 0);
    end
    chk($sformatf("%s_err", tag), err, exp_err);
    chk($sformatf("%s_cpu_run", tag), cpu_run, !exp_err);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_run_seen", tag), run_seen, !exp_err);
    if (acc_cyc.size() == nacc) begin
      if (exp_err) begin
        chk($sformatf("%s_err_cycle", tag), err_cyc, acc_cyc[nacc-1]);
      end else begin
        exp_run = acc_cyc[2*words] + 1;
        if (acc_cyc[nacc-1] > exp_run) exp_run = acc_cyc[nacc-1];
        chk($sformatf("%s_run_cycle", tag), run_cyc, exp_run);
      end
    end
  endtask

  typedef struct { logic [7:0] n; bit exp_err; int exp_words; } vec_t;
  vec_t tbl[7];

  initial begin
    #3ms;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [15:0] w1;
    int n;

    tbl[0] = '{8'd0,   1'b0, 128};
    tbl[1] = '{8'd1,   1'b0, 1};
    tbl[2] = '{8'd2,   1'b0, 2};
    tbl[3] = '{8'd127, 1'b0, 127};
    tbl[4] = '{8'd128, 1'b0, 128};
    tbl[5] = '{8'd129, 1'b1, 0};
    tbl[6] = '{8'd255, 1'b1, 0};

    #2;
    do_reset();
    chk("rdy_before_first_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_first_edge", in_ready, 1);
    chk("busy_idle", busy, 0);

    // Single word, back-to-back bytes
    s.delete(); s.push_back(8'h01); s.push_back(8'hA1); s.push_back(8'h01);
    add_csum(1'b0);
    run_stream("one_word", 0, 0);
    chk("one_word_mem0", mem[0], 16'hA101);

    // in_valid toggling every other cycle
    do_reset();
    s.delete();
    s.push_back(8'h03);
    s.push_back(8'h12); s.push_back(8'h34);
    s.push_back(8'h56); s.push_back(8'h78);
    s.push_back(8'h9A); s.push_back(8'hBC);
    add_csum(1'b0);
    run_stream("toggle", 1, 1);
    chk("toggle_mem0", mem[0], 16'h1234);
    chk("toggle_mem1", mem[1], 16'h5678);
    chk("toggle_mem2", mem[2], 16'h9ABC);

    // Count-byte boundaries
    for (int k = 0; k < 7; k++) begin
      do_reset();
      mk(int'(tbl[k].n));
      add_csum(1'b0);
      run_stream($sformatf("tbl_n%0d", tbl[k].n), 0, 2);
      chk($sformatf("tbl_n%0d_err", tbl[k].n), err, tbl[k].exp_err);
      chk($sformatf("tbl_n%0d_words", tbl[k].n), wq.size(), tbl[k].exp_words);
    end

    // Reset after 2 of 4 words, then reload a single word
    do_reset();
    mk(4);
    for (int i = 0; i < 5; i++) push(s[i], 0, 1, ok);
    w1 = {s[3], s[4]};
    @(posedge clk); #1;
    chk("midload_w1_written", mem[1], w1);
    chk("midload_busy", busy, 1);
    do_reset();
    s.delete(); s.push_back(8'h01); s.push_back(8'hFF); s.push_back(8'hFF);
    add_csum(1'b0);
    run_stream("reload", 0, 0);
    chk("reload_mem0", mem[0], 16'hFFFF);
    chk("reload_mem1_kept", mem[1], w1);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    s.delete(); s.push_back(8'h01); s.push_back(8'hA1); s.push_back(8'h01); s.push_back(8'hA1);
    run_stream("csum_bad", 0, 0);
    chk("csum_bad_mem0", mem[0], 16'hA101);
`endif

    // Random loads
    for (int k = 0; k < 8; k++) begin
      do_reset();
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 129)) : int'($urandom_range(20, 1));
      mk(n);
      add_csum($urandom_range(3, 0) == 0);
      run_stream($sformatf("rnd%0d", k), 0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
